mem_port_array: RTL

- Synthesizable, parametrised multi-port word memory with N_RD independent read ports (mm2s style) and one byte-strobed write port (s2mm style).
- Replaces the fixed three-reader / one-writer host-memory hookup around top_ram, so ports run at full rate without a software memory behind them.
- Adds configurable read latency, per-read valid, out-of-range detection and a read/write collision counter.
- Sits between the DMA-side RAM ports of top_ram and the bench, or an FPGA BRAM wrapper.

---
 rtl/mem_port_pkg.sv | 23 ++
 rtl/mem_port_array_rd_lat_pipe.sv | 41 ++++
 rtl/mem_port_array.sv | 107 ++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared types, default geometry and helpers for the multi-port word memory.
package mem_port_pkg;

    localparam int unsigned DEF_AXI_WIDTH      = 128;
    localparam int unsigned DEF_AXI_ADDR_WIDTH = 32;
    localparam int unsigned DEF_LSB            = $clog2(DEF_AXI_WIDTH) - 3;

    typedef logic [DEF_AXI_WIDTH-1:0]                word_t;
    typedef logic [DEF_AXI_ADDR_WIDTH-DEF_LSB-1:0]   waddr_t;
    typedef logic [DEF_AXI_WIDTH/8-1:0]              strb_t;

    // Saturating add clamped to 2^cnt_w-1.
    function automatic logic [63:0] sat_add(input logic [63:0] count,
                                            input logic [63:0] inc,
                                            input int unsigned cnt_w);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, count} + {1'b0, inc};
        max = (65'd1 << cnt_w) - 65'd1;
        return (sum > max) ? max[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/mem_port_array_rd_lat_pipe.sv
// Per-port read pipeline: STAGES registers of valid/data; data only moves with valid
// so the last stage holds the most recently completed read.
module rd_lat_pipe #(
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [STAGES-1:0] valid_q;
    logic [W-1:0]      data_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: rtl/mem_port_array.sv
// Multi-port word memory: N_RD read-first read ports with configurable latency,
// one byte-strobed write port, out-of-range and collision counters.
module mem_port_array
    import mem_port_pkg::*;
#(
    parameter int unsigned N_RD           = 3,
    parameter int unsigned AXI_WIDTH      = DEF_AXI_WIDTH,
    parameter int unsigned AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned CNT_W          = 16,
    localparam int unsigned LSB           = $clog2(AXI_WIDTH) - 3
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [N_RD-1:0]                       rd_ren,
    input  logic [N_RD*(AXI_ADDR_WIDTH-LSB)-1:0]  rd_addr,
    output logic [N_RD*AXI_WIDTH-1:0]             rd_data,
    output logic [N_RD-1:0]                       rd_valid,
    input  logic                                  wr_wen,
    input  logic [AXI_ADDR_WIDTH-LSB-1:0]         wr_addr,
    input  logic [AXI_WIDTH-1:0]                  wr_data,
    input  logic [AXI_WIDTH/8-1:0]                wr_strb,
    output logic [CNT_W-1:0]                      oob_count,
    output logic [CNT_W-1:0]                      coll_count
);

    localparam int unsigned WA    = AXI_ADDR_WIDTH - LSB;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned NB    = AXI_WIDTH / 8;
    localparam int unsigned INC_W = $clog2(N_RD + 2);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "mem_port_array: RD_LATENCY must be in 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "mem_port_array: DEPTH must be a power of 2");
    end

    logic [AXI_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]     rd_idx    [N_RD];
    logic [N_RD-1:0]      rd_oob;
    logic [AXI_WIDTH-1:0] rd_word_c [N_RD];
    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_oob;
    logic [INC_W-1:0]     oob_inc;
    logic [INC_W-1:0]     coll_inc;

    // Address decode; any set bit above the index makes the access out of range.
    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            rd_idx[i]    = rd_addr[i*WA +: IDX_W];
            rd_oob[i]    = |rd_addr[i*WA + IDX_W +: WA - IDX_W];
            rd_word_c[i] = rd_oob[i] ? '0 : mem[rd_idx[i]];
        end
        wr_idx = wr_addr[IDX_W-1:0];
        wr_oob = |wr_addr[WA-1:IDX_W];
    end

    // Collisions are address matches only, so a zero-strobe write still counts.
    always_comb begin
        oob_inc  = INC_W'(wr_wen && wr_oob);
        coll_inc = '0;
        for (int i = 0; i < N_RD; i++) begin
            oob_inc  = oob_inc + INC_W'(rd_ren[i] && rd_oob[i]);
            coll_inc = coll_inc + INC_W'(rd_ren[i] && wr_wen && !rd_oob[i] && !wr_oob
                                         && (rd_idx[i] == wr_idx));
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_wen && !wr_oob) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oob_count  <= '0;
            coll_count <= '0;
        end else begin
            oob_count  <= CNT_W'(sat_add(64'(oob_count), 64'(oob_inc), CNT_W));
            coll_count <= CNT_W'(sat_add(64'(coll_count), 64'(coll_inc), CNT_W));
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        rd_lat_pipe #(
            .W      (AXI_WIDTH),
            .STAGES (RD_LATENCY)
        ) u_pipe (
            .clk       (clk),
            .rst_n     (rstn),
            .in_valid  (rd_ren[i]),
            .in_data   (rd_word_c[i]),
            .out_valid (rd_valid[i]),
            .out_data  (rd_data[i*AXI_WIDTH +: AXI_WIDTH])
        );
    end

endmodule
